// File: rtl/pipe_pkg.sv
// Shared PIPE encodings and loopback-PHY handshake FSM states.
package pipe_pkg;

  localparam logic [3:0] PD_P0  = 4'b0000;
  localparam logic [3:0] PD_P0S = 4'b0001;
  localparam logic [3:0] PD_P1  = 4'b0010;
  localparam logic [3:0] PD_P2  = 4'b0011;

  localparam logic [2:0] RXSTAT_OK       = 3'b000;
  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DET_WAIT,
    ST_DET_DONE,
    ST_DET_HOLD,
    ST_RATE_WAIT,
    ST_PD_WAIT
  } phy_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pipe_lane_delay.sv
// One lane of Tx->Rx loopback: fixed-depth register pipe with electrical-idle masking.
module pipe_lane_delay #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   tx_data,
  input  logic [WIDTH/8-1:0] tx_datak,
  input  logic               tx_data_valid,
  input  logic               tx_start_block,
  input  logic [1:0]         tx_sync_header,
  input  logic               tx_elec_idle,
  input  logic               rate_wait,
  output logic [WIDTH-1:0]   rx_data,
  output logic [WIDTH/8-1:0] rx_datak,
  output logic               rx_data_valid,
  output logic               rx_valid,
  output logic               rx_start_block,
  output logic [1:0]         rx_sync_header,
  output logic               rx_elec_idle
);

  localparam int unsigned KW = WIDTH / 8;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [KW-1:0]    datak;
    logic             data_valid;
    logic             start_block;
    logic [1:0]       sync_header;
    logic             elec_idle;
  } beat_t;

  localparam beat_t IDLE_BEAT = '{data: '0, datak: '0, data_valid: 1'b0, start_block: 1'b0,
                                  sync_header: 2'b00, elec_idle: 1'b1};

  beat_t stage [LATENCY];
  beat_t tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= IDLE_BEAT;
    end else begin
      stage[0] <= '{data: tx_data, datak: tx_datak, data_valid: tx_data_valid,
                    start_block: tx_start_block, sync_header: tx_sync_header,
                    elec_idle: tx_elec_idle};
      for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[LATENCY-1];

  // Idle beats present as all-zero with RxElectricalIdle high; a rate change only hides validity.
  always_comb begin
    rx_data        = '0;
    rx_datak       = '0;
    rx_data_valid  = 1'b0;
    rx_valid       = 1'b0;
    rx_start_block = 1'b0;
    rx_sync_header = 2'b00;
    rx_elec_idle   = 1'b1;
    if (!tail.elec_idle) begin
      rx_data        = tail.data;
      rx_datak       = tail.datak;
      rx_data_valid  = tail.data_valid & ~rate_wait;
      rx_valid       = ~rate_wait;
      rx_start_block = tail.start_block;
      rx_sync_header = tail.sync_header;
      rx_elec_idle   = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_loopback_phy.sv
// PIPE PHY loopback model: per-lane Tx->Rx delay plus detect/rate/PowerDown handshakes.
module pipe_loopback_phy
  import pipe_pkg::*;
#(
  parameter int unsigned           LANESNUMBER  = 16,
  parameter int unsigned           MAXPIPEWIDTH = 32,
  parameter int unsigned           LOOP_LATENCY = 2,
  parameter int unsigned           DETECT_DELAY = 4,
  parameter int unsigned           RATE_DELAY   = 8,
  parameter int unsigned           PD_DELAY     = 1,
  parameter logic [LANESNUMBER-1:0] LANE_PRESENT = '1
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   TxData,
  input  logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] TxDataK,
  input  logic [LANESNUMBER-1:0]                TxDataValid,
  input  logic [LANESNUMBER-1:0]                TxStartBlock,
  input  logic [2*LANESNUMBER-1:0]              TxSyncHeader,
  input  logic [LANESNUMBER-1:0]                TxElecIdle,
  input  logic [LANESNUMBER-1:0]                TxDetectRx_Loopback,
  input  logic [4*LANESNUMBER-1:0]              PowerDown,
  input  logic [3:0]                            Rate,
  output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   RxData,
  output logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] RxDataK,
  output logic [LANESNUMBER-1:0]                RxDataValid,
  output logic [LANESNUMBER-1:0]                RxValid,
  output logic [LANESNUMBER-1:0]                RxStartBlock,
  output logic [2*LANESNUMBER-1:0]              RxSyncHeader,
  output logic [LANESNUMBER-1:0]                RxElectricalIdle,
  output logic [3*LANESNUMBER-1:0]              RxStatus,
  output logic [LANESNUMBER-1:0]                PhyStatus
);

  localparam int unsigned KW        = MAXPIPEWIDTH / 8;
  localparam int unsigned MAX_DELAY = max3(DETECT_DELAY, RATE_DELAY, PD_DELAY);
  localparam int unsigned CW        = $clog2(MAX_DELAY + 1);

  phy_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    rate_sh_q, rate_sh_d;
  logic [3:0]    rate_pend_q, rate_pend_d;
  logic [3:0]    pd_sh_q, pd_sh_d;
  logic          rst_flag_q;
  logic [3:0]    pd0;
  logic          det_any;
  logic          pulse;
  logic          det_done;
  logic          rate_wait;

  assign pd0     = PowerDown[3:0];
  assign det_any = |TxDetectRx_Loopback;

  always_ff @(posedge CLK) begin
    rst_flag_q <= reset;
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rate_sh_q   <= Rate;
      rate_pend_q <= Rate;
      pd_sh_q     <= pd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rate_sh_q   <= rate_sh_d;
      rate_pend_q <= rate_pend_d;
      pd_sh_q     <= pd_sh_d;
    end
  end

  // DET_WAIT loads DELAY-1 and exits to its own pulse state; RATE/PD_WAIT load DELAY and
  // emit the pulse in their final (count zero) cycle, so all three pulse at request+DELAY+1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rate_sh_d   = rate_sh_q;
    rate_pend_d = rate_pend_q;
    pd_sh_d     = pd_sh_q;
    unique case (state_q)
      ST_IDLE: begin
        if (det_any && pd0 == PD_P1 && TxElecIdle[0]) begin
          state_d = ST_DET_WAIT;
          cnt_d   = CW'(DETECT_DELAY - 1);
        end else if (Rate != rate_sh_q) begin
          state_d     = ST_RATE_WAIT;
          cnt_d       = CW'(RATE_DELAY);
          rate_pend_d = Rate;
        end else if (pd0 != pd_sh_q) begin
          state_d = ST_PD_WAIT;
          cnt_d   = CW'(PD_DELAY);
        end
      end
      ST_DET_WAIT: begin
        if (cnt_q == '0) state_d = ST_DET_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_DET_DONE: state_d = ST_DET_HOLD;
      ST_DET_HOLD: begin
        if (!det_any) state_d = ST_IDLE;
      end
      ST_RATE_WAIT: begin
        if (Rate != rate_pend_q) begin
          rate_pend_d = Rate;
          cnt_d       = CW'(RATE_DELAY);
        end else if (cnt_q == '0) begin
          rate_sh_d = rate_pend_q;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PD_WAIT: begin
        if (cnt_q == '0) begin
          pd_sh_d = pd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pulse     = 1'b0;
    det_done  = 1'b0;
    rate_wait = 1'b0;
    unique case (state_q)
      ST_DET_DONE: begin
        pulse    = 1'b1;
        det_done = 1'b1;
      end
      ST_RATE_WAIT: begin
        rate_wait = 1'b1;
        pulse     = (cnt_q == '0) && (Rate == rate_pend_q);
      end
      ST_PD_WAIT: pulse = (cnt_q == '0);
      default: ;
    endcase
  end

  assign PhyStatus = {LANESNUMBER{pulse | rst_flag_q}};

  for (genvar l = 0; l < LANESNUMBER; l++) begin : g_lane
    assign RxStatus[3*l +: 3] = (det_done && LANE_PRESENT[l]) ? RXSTAT_DETECTED : RXSTAT_OK;

    pipe_lane_delay #(
      .WIDTH   (MAXPIPEWIDTH),
      .LATENCY (LOOP_LATENCY)
    ) u_lane (
      .clk            (CLK),
      .reset          (reset),
      .tx_data        (TxData[l*MAXPIPEWIDTH +: MAXPIPEWIDTH]),
      .tx_datak       (TxDataK[l*KW +: KW]),
      .tx_data_valid  (TxDataValid[l]),
      .tx_start_block (TxStartBlock[l]),
      .tx_sync_header (TxSyncHeader[2*l +: 2]),
      .tx_elec_idle   (TxElecIdle[l]),
      .rate_wait      (rate_wait),
      .rx_data        (RxData[l*MAXPIPEWIDTH +: MAXPIPEWIDTH]),
      .rx_datak       (RxDataK[l*KW +: KW]),
      .rx_data_valid  (RxDataValid[l]),
      .rx_valid       (RxValid[l]),
      .rx_start_block (RxStartBlock[l]),
      .rx_sync_header (RxSyncHeader[2*l +: 2]),
      .rx_elec_idle   (RxElectricalIdle[l])
    );
  end

  // Only lane 0's PowerDown field drives the handshake.
  if (LANESNUMBER > 1) begin : g_pd_upper
    logic pd_upper_unused;
    assign pd_upper_unused = ^PowerDown[4*LANESNUMBER-1:4];
  end

endmodule

// File: tb/tb_pipe_loopback_phy.sv
// Directed scoreboard bench for pipe_loopback_phy: reset, detect, datapath, rate/PD handshakes.
module tb_pipe_loopback_phy;
  import pipe_pkg::*;

  localparam int unsigned     LN      = 16;
  localparam int unsigned     W       = 32;
  localparam int unsigned     KW      = W / 8;
  localparam int unsigned     LAT     = 2;
  localparam int unsigned     DD      = 4;
  localparam int unsigned     RD      = 8;
  localparam int unsigned     PDD     = 1;
  localparam logic [LN-1:0]   PRESENT = 16'h00FF;
  localparam int unsigned     NW      = 8;

  logic                CLK = 1'b0;
  logic                reset;
  logic [W*LN-1:0]     TxData;
  logic [KW*LN-1:0]    TxDataK;
  logic [LN-1:0]       TxDataValid, TxStartBlock, TxElecIdle, TxDetectRx_Loopback;
  logic [2*LN-1:0]     TxSyncHeader;
  logic [4*LN-1:0]     PowerDown;
  logic [3:0]          Rate;
  logic [W*LN-1:0]     RxData;
  logic [KW*LN-1:0]    RxDataK;
  logic [LN-1:0]       RxDataValid, RxValid, RxStartBlock, RxElectricalIdle, PhyStatus;
  logic [2*LN-1:0]     RxSyncHeader;
  logic [3*LN-1:0]     RxStatus;

  always #5 CLK = ~CLK;

  pipe_loopback_phy #(
    .LANESNUMBER  (LN),
    .MAXPIPEWIDTH (W),
    .LOOP_LATENCY (LAT),
    .DETECT_DELAY (DD),
    .RATE_DELAY   (RD),
    .PD_DELAY     (PDD),
    .LANE_PRESENT (PRESENT)
  ) dut (
    .CLK                 (CLK),
    .reset               (reset),
    .TxData              (TxData),
    .TxDataK             (TxDataK),
    .TxDataValid         (TxDataValid),
    .TxStartBlock        (TxStartBlock),
    .TxSyncHeader        (TxSyncHeader),
    .TxElecIdle          (TxElecIdle),
    .TxDetectRx_Loopback (TxDetectRx_Loopback),
    .PowerDown           (PowerDown),
    .Rate                (Rate),
    .RxData              (RxData),
    .RxDataK             (RxDataK),
    .RxDataValid         (RxDataValid),
    .RxValid             (RxValid),
    .RxStartBlock        (RxStartBlock),
    .RxSyncHeader        (RxSyncHeader),
    .RxElectricalIdle    (RxElectricalIdle),
    .RxStatus            (RxStatus),
    .PhyStatus           (PhyStatus)
  );

  typedef struct {
    int unsigned     cyc;
    logic [3*LN-1:0] stat;
  } pulse_t;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] k;
    logic          dv;
    logic          sb;
    logic [1:0]    sh;
    logic          ei;
  } beat_t;

  pulse_t        pulse_q [$];
  beat_t         data_q  [$];
  logic [LN-1:0] valid_q [$];
  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  int unsigned   cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic push_pulse(input int unsigned at, input logic [3*LN-1:0] stat);
    pulse_t p;
    p.cyc  = at;
    p.stat = stat;
    pulse_q.push_back(p);
  endtask

  // Bounded window: every PhyStatus pulse must match the head of pulse_q.
  task automatic watch(input int unsigned n);
    pulse_t        p;
    logic [LN-1:0] ev;
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      if (valid_q.size() > 0) begin
        ev = valid_q.pop_front();
        chk("rx_valid", 64'(RxValid), 64'(ev));
        chk("rx_data_valid", 64'(RxDataValid), 64'(ev));
      end
      if (PhyStatus !== '0) begin
        if (pulse_q.size() == 0) begin
          chk("pulse_extra", 64'(PhyStatus), 64'd0);
        end else begin
          p = pulse_q.pop_front();
          chk("pulse_cycle", 64'(cyc), 64'(p.cyc));
          chk("pulse_value", 64'(PhyStatus), 64'(16'hFFFF));
          chk("pulse_rxstatus", 64'(RxStatus), 64'(p.stat));
        end
      end else begin
        chk("rxstatus_quiet", 64'(RxStatus), 64'd0);
      end
    end
    chk("pulses_pending", 64'(pulse_q.size()), 64'd0);
    pulse_q.delete();
  endtask

  function automatic beat_t expect_beat(input beat_t b);
    beat_t e;
    e = b;
    if (b.ei) begin
      e    = '0;
      e.ei = 1'b1;
    end
    return e;
  endfunction

  initial begin
    logic [3*LN-1:0] det_stat;
    beat_t           b, e, obs;

    reset               = 1'b1;
    TxData              = '0;
    TxDataK             = '0;
    TxDataValid         = '0;
    TxStartBlock        = '0;
    TxSyncHeader        = '0;
    TxElecIdle          = '1;
    TxDetectRx_Loopback = '0;
    PowerDown           = {LN{PD_P1}};
    Rate                = 4'd0;

    // reset held for three edges, released after the third
    for (int i = 0; i < 3; i++) tick();
    chk("rst_phystatus", 64'(PhyStatus), 64'(16'hFFFF));
    chk("rst_rx_ei", 64'(RxElectricalIdle), 64'(16'hFFFF));
    chk("rst_rx_valid", 64'(RxValid), 64'd0);
    chk("rst_rx_status", 64'(RxStatus), 64'd0);
    chk("rst_rx_data_l5", 64'(RxData[5*W +: W]), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_phystatus", 64'(PhyStatus), 64'd0);

    // receiver detect in P1 with electrical idle
    for (int l = 0; l < LN; l++) det_stat[3*l +: 3] = PRESENT[l] ? 3'b011 : 3'b000;
    TxDetectRx_Loopback = '1;
    push_pulse(cyc + DD + 1, det_stat);
    watch(DD + 8);
    TxDetectRx_Loopback = '0;
    watch(3);

    // enter P0 and start driving traffic
    PowerDown   = {LN{PD_P0}};
    TxElecIdle  = '0;
    TxDataValid = '1;
    push_pulse(cyc + PDD + 1, '0);
    watch(PDD + 4);

    // lane 5 datapath with latency and idle masking
    for (int unsigned i = 0; i < NW + LAT - 1; i++) begin
      if (i < NW) begin
        if (i == 0) begin
          b = '{data: 32'hA5A5_1234, k: 4'b0001, dv: 1'b1, sb: 1'b1, sh: 2'b10, ei: 1'b0};
        end else begin
          b.data = $urandom;
          b.k    = 4'($urandom_range(0, 15));
          b.dv   = 1'($urandom_range(0, 1));
          b.sb   = 1'($urandom_range(0, 1));
          b.sh   = 2'($urandom_range(0, 3));
          b.ei   = (i == 4);
        end
        TxData[5*W +: W]      = b.data;
        TxDataK[5*KW +: KW]   = b.k;
        TxDataValid[5]        = b.dv;
        TxStartBlock[5]       = b.sb;
        TxSyncHeader[10 +: 2] = b.sh;
        TxElecIdle[5]         = b.ei;
        data_q.push_back(expect_beat(b));
      end else begin
        TxElecIdle[5]  = 1'b0;
        TxDataValid[5] = 1'b1;
      end
      tick();
      if (i >= LAT - 1 && data_q.size() > 0) begin
        e   = data_q.pop_front();
        obs = '{data: RxData[5*W +: W], k: RxDataK[5*KW +: KW], dv: RxDataValid[5],
                sb: RxStartBlock[5], sh: RxSyncHeader[10 +: 2], ei: RxElectricalIdle[5]};
        chk("lane5_beat", 64'(obs), 64'(e));
        chk("lane5_rxvalid", 64'(RxValid[5]), 64'(!e.ei));
      end
    end
    TxElecIdle  = '0;
    TxDataValid = '1;
    for (int unsigned i = 0; i < LAT + 1; i++) tick();

    // rate change mid-stream blanks validity for RD+1 cycles
    Rate = 4'd1;
    push_pulse(cyc + RD + 1, '0);
    for (int unsigned i = 0; i < RD + 1; i++) valid_q.push_back('0);
    for (int unsigned i = 0; i < 3; i++) valid_q.push_back('1);
    watch(RD + 6);

    // simultaneous rate and PowerDown change: rate pulse, IDLE, then PD pulse
    Rate      = 4'd2;
    PowerDown = {LN{PD_P0S}};
    push_pulse(cyc + RD + 1, '0);
    push_pulse(cyc + RD + 3 + PDD, '0);
    for (int unsigned i = 0; i < RD + 1; i++) valid_q.push_back('0);
    for (int unsigned i = 0; i < 4; i++) valid_q.push_back('1);
    watch(RD + 10);

    // rate change during RATE_WAIT restarts the count: one pulse only
    Rate = 4'd3;
    watch(3);
    Rate = 4'd0;
    push_pulse(cyc + RD + 1, '0);
    watch(RD + 8);

    // reset during DET_WAIT aborts the handshake and flushes the pipe
    PowerDown  = {LN{PD_P1}};
    TxElecIdle = 16'h0001;
    push_pulse(cyc + PDD + 1, '0);
    watch(PDD + 4);
    chk("pre_abort_rx_ei", 64'(RxElectricalIdle), 64'(16'h0001));
    TxDetectRx_Loopback = '1;
    watch(2);
    reset = 1'b1;
    tick();
    chk("abort_phystatus", 64'(PhyStatus), 64'(16'hFFFF));
    chk("abort_flush_ei", 64'(RxElectricalIdle), 64'(16'hFFFF));
    chk("abort_flush_valid", 64'(RxValid), 64'd0);
    tick();
    reset               = 1'b0;
    TxDetectRx_Loopback = '0;
    tick();
    chk("abort_release_phystatus", 64'(PhyStatus), 64'd0);
    watch(DD + 4);

    // FSM back in IDLE: a fresh PowerDown change handshakes on time
    PowerDown = {LN{PD_P0}};
    push_pulse(cyc + PDD + 1, '0);
    watch(PDD + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
